decoder_nto2n_scan: RTL and testbench



---
 rtl/decoder_nto2n_scan_pkg.sv | 18 +
 rtl/decoder_nto2n_scan_prescaler.sv | 29 ++
 rtl/decoder_nto2n_scan.sv | 66 ++++++
 tb/tb_decoder_nto2n_scan.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/decoder_nto2n_scan_pkg.sv
// Shared constants and helpers for the line decoder family.
package decoder_nto2n_scan_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Returns a 64-bit vector with bit idx set; callers truncate to 2^n bits.
   function automatic logic [63:0] onehot(input logic [5:0] idx, input int unsigned n);
      logic [63:0] v;
      logic [31:0] lim;
      v   = '0;
      lim = 32'(1) << n;
      if (32'(idx) < lim)
         v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/decoder_nto2n_scan_prescaler.sv
// Modulo-DIV counter with synchronous clear, count enable and terminal-count flag.
module scan_prescaler #(
   parameter int unsigned DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;

   logic [PW-1:0] cnt;

   assign tc = en && (cnt == PW'(DIV - 1));

   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en) begin
         if (tc)
            cnt <= '0;
         else
            cnt <= cnt + PW'(1);
      end
   end

endmodule

// File: rtl/decoder_nto2n_scan.sv
// Registered N-to-2^N decoder with direct select and prescaled auto-scan.
module decoder_nto2n_scan
   import decoder_nto2n_scan_pkg::*;
#(
   parameter int unsigned N          = 3,
   parameter int unsigned DIV        = 4,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              mode,
   input  logic [N-1:0]      sel,
   output logic [(1<<N)-1:0] out,
   output logic [N-1:0]      idx,
   output logic              active,
   output logic              step
);

   localparam int unsigned W = 1 << N;

   logic         scan;
   logic         tc;
   logic [N-1:0] ptr;
   logic [N-1:0] line;
   logic [W-1:0] dec;

   scan_prescaler #(.DIV(DIV)) u_prescaler (
      .clk (clk),
      .rst (rst),
      .clr (!scan),
      .en  (scan),
      .tc  (tc)
   );

   // line is the pointer value after this edge; out, idx and step all derive from it.
   always_comb begin
      scan = en && (mode == MODE_SCAN);
      line = sel;
      if (scan)
         line = tc ? ptr + N'(1) : ptr;
      dec = W'(onehot(6'(line), N));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr    <= '0;
         out    <= {W{ACTIVE_LOW}};
         active <= 1'b0;
         step   <= 1'b0;
      end else if (!en) begin
         out    <= {W{ACTIVE_LOW}};
         active <= 1'b0;
         step   <= 1'b0;
      end else begin
         ptr    <= line;
         out    <= dec ^ {W{ACTIVE_LOW}};
         active <= 1'b1;
         step   <= tc;
      end
   end

   // The pointer register doubles as the idx output.
   assign idx = ptr;

endmodule

// File: tb/tb_decoder_nto2n_scan.sv
// Randomised and directed checks of two decoder configurations against a behavioural model.
module tb_decoder_nto2n_scan;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, en, mode;
   logic [2:0] sel;

   logic [7:0] out_a;
   logic [2:0] idx_a;
   logic       active_a, step_a;
   logic [3:0] out_b;
   logic [1:0] idx_b;
   logic       active_b, step_b;

   decoder_nto2n_scan #(.N(3), .DIV(4), .ACTIVE_LOW(1'b0)) dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
      .out(out_a), .idx(idx_a), .active(active_a), .step(step_a)
   );

   decoder_nto2n_scan #(.N(2), .DIV(1), .ACTIVE_LOW(1'b1)) dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel[1:0]),
      .out(out_b), .idx(idx_b), .active(active_b), .step(step_b)
   );

   int checks = 0;
   int errors = 0;

   int pa = 0, ca = 0, pb = 0, cb = 0;
   int eoa, eia, eaa, esa;
   int eob, eib, eab, esb;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Behavioural model of one edge: w lines, divide-by-div scan, optional inversion.
   task automatic model(input int w, input int div, input bit al, inout int ptr, inout int cnt,
                        output int eo, output int ei, output int eact, output int estep);
      int msk;
      int inv;
      msk = (1 << w) - 1;
      inv = al ? msk : 0;
      if (rst) begin
         ptr = 0; cnt = 0; eo = inv; ei = 0; eact = 0; estep = 0;
      end else if (!en) begin
         cnt = 0; eo = inv; ei = ptr; eact = 0; estep = 0;
      end else if (!mode) begin
         ptr = int'(sel) % w; cnt = 0;
         eo = (1 << ptr) ^ inv; ei = ptr; eact = 1; estep = 0;
      end else begin
         estep = (cnt == div - 1) ? 1 : 0;
         cnt   = estep ? 0 : cnt + 1;
         if (estep) ptr = (ptr + 1) % w;
         eo = (1 << ptr) ^ inv; ei = ptr; eact = 1;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model(8, 4, 1'b0, pa, ca, eoa, eia, eaa, esa);
      model(4, 1, 1'b1, pb, cb, eob, eib, eab, esb);
      #1;
      check("a_out", out_a, 64'(eoa));
      check("a_idx", idx_a, 64'(eia));
      check("a_active", active_a, 64'(eaa));
      check("a_step", step_a, 64'(esa));
      check("b_out", out_b, 64'(eob));
      check("b_idx", idx_b, 64'(eib));
      check("b_active", active_b, 64'(eab));
      check("b_step", step_b, 64'(esb));
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; mode = 1'b0; sel = '0;
      tick();
      check("rst_out_a", out_a, 64'h00);
      check("rst_out_b", out_b, 64'hF);
      rst = 1'b0;

      // direct sweep
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sel = 3'(i);
         tick();
         check("sweep_out", out_a, 64'(1) << i);
         check("sweep_idx", idx_a, 64'(i));
      end

      // scan from reset with wrap
      rst = 1'b1; tick(); rst = 1'b0;
      mode = 1'b1;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (i == 3)  check("scan_first_adv", out_a, 64'h02);
         if (i == 31) check("scan_wrap_out", out_a, 64'h01);
         if (i == 31) check("scan_wrap_step", step_a, 64'h1);
      end

      // direct to scan handover
      mode = 1'b0; sel = 3'd5; tick();
      check("hand_direct", out_a, 64'h20);
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("hand_hold", out_a, 64'h20);
      end
      tick();
      check("hand_adv", out_a, 64'h40);
      check("hand_step", step_a, 64'h1);
      tick();
      mode = 1'b0; sel = 3'd2; tick();
      check("scan_to_direct", out_a, 64'h04);
      check("scan_to_direct_step", step_a, 64'h0);

      // enable drop mid-scan at ptr=3
      mode = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      check("pre_drop_idx", idx_a, 64'h3);
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("drop_out", out_a, 64'h00);
         check("drop_active", active_a, 64'h0);
      end
      en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("reen_hold", out_a, 64'h08);
      end
      tick();
      check("reen_adv", out_a, 64'h10);

      // reset mid-scan at ptr=6
      for (int i = 0; i < 8; i++) tick();
      check("pre_rst_idx", idx_a, 64'h6);
      rst = 1'b1; tick();
      check("midrst_out", out_a, 64'h00);
      check("midrst_idx", idx_a, 64'h0);
      rst = 1'b0; tick();
      check("post_rst_out", out_a, 64'h01);

      // randomised traffic
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 99) == 0);
         en  = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         sel = 3'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
